// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and the CDB packet layout used by the result slots, the bus
// register and every CDB consumer.
package cdb_arbiter_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ROB_TAG_LEN = 5;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        data;
        logic [XLEN-1:0]        target_pc;
        logic                   mispredict;
    } cdb_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// modulo N. The grant is one-hot, or zero when nothing requests.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PW'((32'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects FU results into one-entry slots and broadcasts at most one per cycle
// on a registered common data bus, with round-robin fairness and ROB flush.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [NUM_FU-1:0]                       fu_valid,
    input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]      fu_rob_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]             fu_data,
    input  logic [NUM_FU-1:0][XLEN-1:0]             fu_target_pc,
    input  logic [NUM_FU-1:0]                       fu_mispredict,
    output logic [NUM_FU-1:0]                       fu_ready,
    output logic                                    cdb_valid,
    output logic [ROB_TAG_LEN-1:0]                  cdb_rob_tag,
    output logic [XLEN-1:0]                         cdb_data,
    output logic [XLEN-1:0]                         cdb_target_pc,
    output logic                                    cdb_mispredict
);

    localparam int unsigned PW = $clog2(NUM_FU);

    cdb_packet_t       r_slot [NUM_FU];
    cdb_packet_t       r_cdb;
    logic [PW-1:0]     r_rr_ptr;

    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_grant;
    logic [PW-1:0]     w_gidx;
    logic [PW-1:0]     w_ptr_nxt;

    always_comb begin
        w_req = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            w_req[i] = r_slot[i].valid;
        end
    end

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    // Encode the one-hot grant and advance the pointer past the winner.
    always_comb begin
        w_gidx = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (w_grant[i]) begin
                w_gidx = PW'(i);
            end
        end
        w_ptr_nxt = (32'(w_gidx) == NUM_FU - 1) ? '0 : PW'(32'(w_gidx) + 32'd1);
    end

    // A granted slot drains this edge, so it can be refilled on the same edge.
    assign fu_ready = {NUM_FU{reset && !flush}} & (~w_req | w_grant);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                r_slot[i] <= '0;
            end
            r_cdb    <= '0;
            r_rr_ptr <= '0;
        end else if (flush) begin
            // Payloads are retained; only the valid bits are dropped.
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                r_slot[i].valid <= 1'b0;
            end
            r_cdb.valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    r_slot[i] <= '{valid:      1'b1,
                                   rob_tag:    fu_rob_tag[i],
                                   data:       fu_data[i],
                                   target_pc:  fu_target_pc[i],
                                   mispredict: fu_mispredict[i]};
                end else if (w_grant[i]) begin
                    r_slot[i].valid <= 1'b0;
                end
            end
            if (|w_grant) begin
                r_cdb    <= r_slot[w_gidx];
                r_rr_ptr <= w_ptr_nxt;
            end else begin
                r_cdb.valid <= 1'b0;
            end
        end
    end

    assign cdb_valid      = r_cdb.valid;
    assign cdb_rob_tag    = r_cdb.rob_tag;
    assign cdb_data       = r_cdb.data;
    assign cdb_target_pc  = r_cdb.target_pc;
    assign cdb_mispredict = r_cdb.mispredict;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts and
// cycle-stamped status checks; a negedge monitor pops and compares them.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NF = 4;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             flush;
    logic [NF-1:0]                    fu_valid;
    logic [NF-1:0][ROB_TAG_LEN-1:0]   fu_rob_tag;
    logic [NF-1:0][XLEN-1:0]          fu_data;
    logic [NF-1:0][XLEN-1:0]          fu_target_pc;
    logic [NF-1:0]                    fu_mispredict;
    logic [NF-1:0]                    fu_ready;
    logic                             cdb_valid;
    logic [ROB_TAG_LEN-1:0]           cdb_rob_tag;
    logic [XLEN-1:0]                  cdb_data;
    logic [XLEN-1:0]                  cdb_target_pc;
    logic                             cdb_mispredict;

    cdb_arbiter #(.NUM_FU(NF)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .fu_valid       (fu_valid),
        .fu_rob_tag     (fu_rob_tag),
        .fu_data        (fu_data),
        .fu_target_pc   (fu_target_pc),
        .fu_mispredict  (fu_mispredict),
        .fu_ready       (fu_ready),
        .cdb_valid      (cdb_valid),
        .cdb_rob_tag    (cdb_rob_tag),
        .cdb_data       (cdb_data),
        .cdb_target_pc  (cdb_target_pc),
        .cdb_mispredict (cdb_mispredict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int unsigned BW = ROB_TAG_LEN + 2 * XLEN + 1;

    typedef struct {
        int                     cyc;
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        data;
        logic [XLEN-1:0]        tpc;
        logic                   mp;
    } bus_exp_t;

    // kind 0: fu_ready & mask, kind 1: cdb_valid, kind 2: all payload fields
    typedef struct {
        int            cyc;
        int            kind;
        logic [NF-1:0] mask;
        logic [BW-1:0] val;
    } chk_t;

    bus_exp_t bus_q[$];
    chk_t     chk_q[$];
    int       n_vec = 0;
    int       n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_bus(input int at, input logic [ROB_TAG_LEN-1:0] tag,
                           input logic [XLEN-1:0] d, input logic [XLEN-1:0] tpc,
                           input logic mp);
        bus_exp_t e;
        e.cyc = at; e.tag = tag; e.data = d; e.tpc = tpc; e.mp = mp;
        bus_q.push_back(e);
    endtask

    task automatic exp_chk(input int at, input int kind, input logic [NF-1:0] mask,
                           input logic [BW-1:0] val);
        chk_t c;
        c.cyc = at; c.kind = kind; c.mask = mask; c.val = val;
        chk_q.push_back(c);
    endtask

    task automatic present(input int i, input logic [ROB_TAG_LEN-1:0] tag,
                           input logic [XLEN-1:0] d, input logic [XLEN-1:0] tpc,
                           input logic mp);
        fu_valid[i]      = 1'b1;
        fu_rob_tag[i]    = tag;
        fu_data[i]       = d;
        fu_target_pc[i]  = tpc;
        fu_mispredict[i] = mp;
    endtask

    task automatic idle_inputs();
        fu_valid      = '0;
        fu_rob_tag    = '0;
        fu_data       = '0;
        fu_target_pc  = '0;
        fu_mispredict = '0;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin : monitor
        bus_exp_t      e;
        chk_t          c;
        logic [BW-1:0] act;
        forever begin
            @(negedge clk);
            while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
                e = bus_q.pop_front();
                n_vec++; n_err++;
                $display("FAIL bus_missing: tag=%0d expected in cycle %0d, never broadcast",
                         e.tag, e.cyc);
            end
            if (cdb_valid !== 1'b0) begin
                n_vec++;
                if (bus_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bus_unexpected: cycle %0d cdb_valid=%b tag=%0d data=%h, none required",
                             cyc, cdb_valid, cdb_rob_tag, cdb_data);
                end else begin
                    e = bus_q.pop_front();
                    if (cdb_valid !== 1'b1 || e.cyc != cyc || cdb_rob_tag !== e.tag ||
                        cdb_data !== e.data || cdb_target_pc !== e.tpc ||
                        cdb_mispredict !== e.mp) begin
                        n_err++;
                        $display("FAIL bus_packet: got cyc=%0d v=%b tag=%0d data=%h tpc=%h mp=%b, required cyc=%0d tag=%0d data=%h tpc=%h mp=%b",
                                 cyc, cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict,
                                 e.cyc, e.tag, e.data, e.tpc, e.mp);
                    end
                end
            end
            while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
                c = chk_q.pop_front();
                n_vec++;
                case (c.kind)
                    0:       act = BW'(fu_ready & c.mask);
                    1:       act = BW'(cdb_valid);
                    default: act = {cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict};
                endcase
                if (c.cyc != cyc || act !== c.val) begin
                    n_err++;
                    $display("FAIL status_kind%0d: cycle %0d got %h, required %h in cycle %0d",
                             c.kind, cyc, act, c.val, c.cyc);
                end
            end
        end
    end

    initial begin : stim
        int k;
        reset = 1'b0;
        flush = 1'b0;
        idle_inputs();
        fu_valid = '1;

        // Reset held across three edges with every FU asserting valid.
        exp_chk(1, 0, 4'hF, '0);
        exp_chk(1, 1, '0, '0);
        exp_chk(1, 2, '0, '0);
        exp_chk(2, 0, 4'hF, '0);
        exp_chk(2, 1, '0, '0);
        tick(); tick(); tick();
        reset = 1'b1;
        idle_inputs();
        exp_chk(cyc, 0, 4'hF, BW'(4'hF));
        tick(); tick();

        // Single result on FU2.
        k = cyc;
        present(2, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        exp_bus(k + 2, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        tick(); idle_inputs();
        tick(); tick(); tick();

        // Flush with nothing in flight to return the pointer to 0.
        flush = 1'b1;
        exp_chk(cyc, 0, 4'hF, '0);
        tick(); flush = 1'b0;
        tick();

        // All four FUs at once: order 0,1,2,3, FU3 stalled until its grant.
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            present(i, 5'(i), 32'h1000 + 32'(i), 32'h0, 1'b0);
            exp_bus(k + 2 + i, 5'(i), 32'h1000 + 32'(i), 32'h0, 1'b0);
        end
        exp_chk(k + 1, 0, 4'h8, '0);
        exp_chk(k + 2, 0, 4'h8, '0);
        exp_chk(k + 3, 0, 4'h8, '0);
        exp_chk(k + 4, 0, 4'h8, BW'(4'h8));
        tick(); idle_inputs();
        repeat (6) tick();

        // FU1 streams three results back to back.
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            present(1, 5'(i + 1), 32'h2000 + 32'(i), 32'h0, 1'b0);
            exp_bus(k + 2 + i, 5'(i + 1), 32'h2000 + 32'(i), 32'h0, 1'b0);
            exp_chk(k + i, 0, 4'h2, BW'(4'h2));
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        // Pointer back to 0, then flush in the cycle slot 0 wins.
        flush = 1'b1;
        tick(); flush = 1'b0;
        tick();
        k = cyc;
        present(0, 5'd7, 32'h7777, 32'h0, 1'b0);
        present(3, 5'd8, 32'h8888, 32'h0, 1'b0);
        tick(); idle_inputs();
        flush = 1'b1;
        exp_chk(k + 1, 0, 4'hF, '0);
        tick(); flush = 1'b0;
        exp_chk(k + 2, 1, '0, '0);
        exp_chk(k + 2, 0, 4'hF, BW'(4'hF));
        present(3, 5'd9, 32'h9999, 32'h0, 1'b0);
        exp_bus(k + 4, 5'd9, 32'h9999, 32'h0, 1'b0);
        tick(); idle_inputs();
        repeat (4) tick();

        // Mispredict and target PC pass through.
        k = cyc;
        present(0, 5'd3, 32'hABCD, 32'h0000_1040, 1'b1);
        exp_bus(k + 2, 5'd3, 32'hABCD, 32'h0000_1040, 1'b1);
        tick(); idle_inputs();
        repeat (3) tick();

        // Reset in the grant cycle: no broadcast, payload zeroed.
        k = cyc;
        present(2, 5'd11, 32'h5555, 32'h4444, 1'b1);
        tick(); idle_inputs();
        reset = 1'b0;
        exp_chk(k + 1, 0, 4'hF, '0);
        tick(); reset = 1'b1;
        exp_chk(k + 2, 1, '0, '0);
        exp_chk(k + 2, 2, '0, '0);
        exp_chk(k + 2, 0, 4'hF, BW'(4'hF));
        present(1, 5'd12, 32'hC0DE, 32'h0, 1'b0);
        exp_bus(k + 4, 5'd12, 32'hC0DE, 32'h0, 1'b0);
        tick(); idle_inputs();

        repeat (6) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
